// File: rtl/tl_interval_timer.sv
// Retriggerable interval timer for the traffic-light phase sequencer.
// The duration is chosen per start from two presets or a runtime load value.
// It supports a prescaler, hold, abort and periodic auto-reload.
// Optional feature macro: TL_TIMER_OVERRUN_EN adds a sticky overrun_o flag.
module tl_interval_timer #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SHORT_TICKS = 5,
    parameter int unsigned LONG_TICKS  = 20,
    parameter int unsigned PRESC_DIV   = 1
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             start_i,
    input  logic [1:0]       sel_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             hold_i,
    input  logic             abort_i,
    input  logic             periodic_i,
    output logic             busy_o,
    output logic             done_pulse_o,
    output logic             expired_o,
`ifdef TL_TIMER_OVERRUN_EN
    output logic             overrun_o,
`endif
    output logic [CNT_W-1:0] remaining_o
);

    localparam int unsigned PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StExpired} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] dur_q;
    logic [CNT_W-1:0] dur_sel;
    logic [PW-1:0]    presc_q;
    logic             periodic_q;
    logic             done_q;
    logic             expired_q;
    logic             tick;

    // Duration requested by the current start; a zero load value runs for one tick.
    always_comb begin
        dur_sel = CNT_W'(SHORT_TICKS);
        unique case (sel_i)
            2'b01:   dur_sel = CNT_W'(LONG_TICKS);
            2'b10:   dur_sel = (load_val_i == '0) ? CNT_W'(1) : load_val_i;
            default: dur_sel = CNT_W'(SHORT_TICKS);
        endcase
    end

    assign tick = (state_q == StRun) && !hold_i && (presc_q == PW'(PRESC_DIV - 1));

    // Timer FSM: abort beats start, start beats expiry; all outputs registered.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q    <= StIdle;
            rem_q      <= '0;
            dur_q      <= '0;
            presc_q    <= '0;
            periodic_q <= 1'b0;
            done_q     <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                state_q   <= StIdle;
                rem_q     <= '0;
                presc_q   <= '0;
                expired_q <= 1'b0;
            end else if (start_i) begin
                state_q    <= StRun;
                rem_q      <= dur_sel;
                dur_q      <= dur_sel;
                presc_q    <= '0;
                periodic_q <= periodic_i;
                expired_q  <= 1'b0;
            end else if (state_q == StRun && !hold_i) begin
                if (tick) begin
                    presc_q <= '0;
                    if (rem_q == CNT_W'(1)) begin
                        done_q <= 1'b1;
                        if (periodic_q) begin
                            rem_q <= dur_q;
                        end else begin
                            rem_q     <= '0;
                            expired_q <= 1'b1;
                            state_q   <= StExpired;
                        end
                    end else begin
                        rem_q <= rem_q - CNT_W'(1);
                    end
                end else begin
                    presc_q <= presc_q + PW'(1);
                end
            end
        end
    end

`ifdef TL_TIMER_OVERRUN_EN
    logic overrun_q;

    // Sticky flag: a start or abort that interrupts a running interval.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            overrun_q <= 1'b0;
        end else if (state_q == StRun && (start_i || abort_i)) begin
            overrun_q <= 1'b1;
        end else if (start_i && !abort_i) begin
            overrun_q <= 1'b0;
        end
    end

    assign overrun_o = overrun_q;
`endif

    assign busy_o       = (state_q == StRun);
    assign done_pulse_o = done_q;
    assign expired_o    = expired_q;
    assign remaining_o  = rem_q;

endmodule

// File: tb/tb_tl_interval_timer.sv
// Directed bench for tl_interval_timer with default parameters
// (CNT_W=8, SHORT_TICKS=5, LONG_TICKS=20, PRESC_DIV=1).
module tb_tl_interval_timer;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       start;
    logic [1:0] sel;
    logic [7:0] load_val;
    logic       hold;
    logic       abort;
    logic       periodic;
    logic       busy;
    logic       done_pulse;
    logic       expired;
    logic [7:0] remaining;
`ifdef TL_TIMER_OVERRUN_EN
    logic       overrun;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tl_interval_timer dut (
        .clk_i        (clk),
        .arst_ni      (arst_n),
        .start_i      (start),
        .sel_i        (sel),
        .load_val_i   (load_val),
        .hold_i       (hold),
        .abort_i      (abort),
        .periodic_i   (periodic),
        .busy_o       (busy),
        .done_pulse_o (done_pulse),
        .expired_o    (expired),
`ifdef TL_TIMER_OVERRUN_EN
        .overrun_o    (overrun),
`endif
        .remaining_o  (remaining)
    );

    typedef struct {
        logic       start;
        logic [1:0] sel;
        logic [7:0] load;
        logic       hold;
        logic       abort;
        logic       periodic;
        logic       busy;
        logic       done;
        logic       exp;
        logic [7:0] rem;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic st, logic [1:0] s, logic [7:0] ld, logic h, logic ab,
                               logic per, logic b, logic d, logic e, logic [7:0] r);
        vec_t x;
        x.start = st; x.sel = s; x.load = ld; x.hold = h; x.abort = ab; x.periodic = per;
        x.busy = b; x.done = d; x.exp = e; x.rem = r;
        return x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply inputs, clock once, then sample just after the edge.
    task automatic step(logic st, logic [1:0] s, logic [7:0] ld, logic h, logic ab, logic per);
        start = st; sel = s; load_val = ld; hold = h; abort = ab; periodic = per;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int  cyc;
        bit  seen;
        arst_n = 1'b0;
        start = 0; sel = 0; load_val = 0; hold = 0; abort = 0; periodic = 0;

        // Single-start short run
        vecs.push_back(v(1, 2'b00, 0, 0, 0, 0, 1, 0, 0, 5));
        vecs.push_back(v(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 4));
        vecs.push_back(v(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 3));
        vecs.push_back(v(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2));
        vecs.push_back(v(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(v(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0));
        // load_val=0 behaves as one tick
        vecs.push_back(v(1, 2'b10, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(v(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0));
        // Periodic load_val=3, three periods
        vecs.push_back(v(1, 2'b10, 3, 0, 0, 1, 1, 0, 0, 3));
        for (int i = 0; i < 3; i++) begin
            vecs.push_back(v(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2));
            vecs.push_back(v(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 1));
            vecs.push_back(v(0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 3));
        end
        vecs.push_back(v(0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
        // Retrigger at remaining=2
        vecs.push_back(v(1, 2'b00, 0, 0, 0, 0, 1, 0, 0, 5));
        vecs.push_back(v(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 4));
        vecs.push_back(v(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 3));
        vecs.push_back(v(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2));
        vecs.push_back(v(1, 2'b00, 0, 0, 0, 0, 1, 0, 0, 5));
        vecs.push_back(v(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 4));
        // abort beats start
        vecs.push_back(v(1, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
        // Start coinciding with the expiry tick
        vecs.push_back(v(1, 2'b00, 0, 0, 0, 0, 1, 0, 0, 5));
        vecs.push_back(v(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 4));
        vecs.push_back(v(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 3));
        vecs.push_back(v(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2));
        vecs.push_back(v(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(v(1, 2'b00, 0, 0, 0, 0, 1, 0, 0, 5));
        vecs.push_back(v(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 4));
        vecs.push_back(v(0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done_pulse), 0);
        chk("rst_expired", 32'(expired), 0);
        chk("rst_remaining", 32'(remaining), 0);
        @(negedge clk);
        arst_n = 1'b1;
        idle();

        foreach (vecs[i]) begin
            step(vecs[i].start, vecs[i].sel, vecs[i].load, vecs[i].hold, vecs[i].abort,
                 vecs[i].periodic);
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("vec%0d_done", i), 32'(done_pulse), 32'(vecs[i].done));
            chk($sformatf("vec%0d_expired", i), 32'(expired), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_remaining", i), 32'(remaining), 32'(vecs[i].rem));
        end

        // Long run held for 7 cycles at remaining=12: done 27 edges after start
        step(1'b1, 2'b01, 8'd0, 1'b0, 1'b0, 1'b0);
        cyc = 0;
        repeat (8) begin idle(); cyc++; end
        chk("hold_pre_rem", 32'(remaining), 12);
        repeat (7) begin
            step(1'b0, 2'b00, 8'd0, 1'b1, 1'b0, 1'b0);
            cyc++;
            chk("hold_frozen_rem", 32'(remaining), 12);
            chk("hold_no_done", 32'(done_pulse), 0);
        end
        seen = 0;
        while (!seen && cyc < 60) begin
            idle();
            cyc++;
            if (done_pulse) seen = 1;
        end
        chk("hold_done_seen", 32'(seen), 1);
        chk("hold_done_latency", 32'(cyc), 27);
        chk("hold_expired", 32'(expired), 1);

        // Asynchronous reset mid-run
        step(1'b1, 2'b01, 8'd0, 1'b0, 1'b0, 1'b0);
        repeat (10) idle();
        chk("arst_pre_rem", 32'(remaining), 10);
        #2;
        arst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done_pulse), 0);
        chk("arst_expired", 32'(expired), 0);
        chk("arst_remaining", 32'(remaining), 0);
        @(negedge clk);
        arst_n = 1'b1;
        repeat (3) idle();
        chk("post_arst_busy", 32'(busy), 0);
        chk("post_arst_remaining", 32'(remaining), 0);
        chk("post_arst_expired", 32'(expired), 0);

`ifdef TL_TIMER_OVERRUN_EN
        step(1'b1, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("ovr_clear_start", 32'(overrun), 0);
        idle();
        step(1'b1, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("ovr_set_retrigger", 32'(overrun), 1);
        repeat (5) idle();
        chk("ovr_expired", 32'(expired), 1);
        chk("ovr_sticky", 32'(overrun), 1);
        step(1'b1, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("ovr_cleared", 32'(overrun), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
